// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID register: PC ownership, req/ack imem fetch, stall/flush/redirect.
// Optional FETCH_STATS_EN adds saturating fetch_count/kill_count outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_d,
    output logic [5:0]  op_d,
    output logic [5:0]  funct_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [15:0] kill_count
`endif
);

    typedef enum logic [1:0] {StFetch, StStall, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic        req_raw;
    logic        load;
    logic [31:0] load_word;
    logic        bubble;
    logic        kill;

    // Branch resolution beats a jump still sitting in decode.
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ack) begin
                    if (!redirect && stall_d) begin
                        state_d = StStall;
                    end
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StStall: begin
                if (redirect || !stall_d) begin
                    state_d = StFetch;
                end
            end
            StDrop: begin
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        req_raw    = 1'b0;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_word  = imem_rdata;
        bubble     = 1'b0;
        kill       = 1'b0;
        unique case (state_q)
            StFetch: begin
                req_raw = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        kill       = 1'b1;
                        bubble     = 1'b1;
                        pc_d       = target;
                        req_addr_d = target;
                    end else if (!stall_d) begin
                        load       = 1'b1;
                        pc_d       = pc_plus4;
                        req_addr_d = pc_plus4;
                    end else begin
                        hold_d = imem_rdata;
                    end
                end else if (redirect) begin
                    // Request stays on the bus at the old address until acked.
                    pc_d   = target;
                    bubble = 1'b1;
                end else if (!stall_d) begin
                    bubble = 1'b1;
                end
            end
            StStall: begin
                if (redirect) begin
                    kill       = 1'b1;
                    bubble     = 1'b1;
                    pc_d       = target;
                    req_addr_d = target;
                end else if (!stall_d) begin
                    load       = 1'b1;
                    load_word  = hold_q;
                    pc_d       = pc_plus4;
                    req_addr_d = pc_plus4;
                end
            end
            StDrop: begin
                req_raw = 1'b1;
                bubble  = 1'b1;
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    kill       = 1'b1;
                    req_addr_d = redirect ? target : pc_q;
                end
            end
            default: begin
                req_raw = 1'b0;
            end
        endcase
        // A freshly loaded word takes precedence over the flush.
        if (flush_d) begin
            bubble = 1'b1;
        end
        imem_req = req_raw & ~rst;
    end

    assign imem_addr = req_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_q     <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else if (load) begin
            instr_q    <= load_word;
            pc_plus4_q <= pc_plus4;
            valid_q    <= 1'b1;
        end else if (bubble) begin
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end
    end

    assign instr_d    = instr_q;
    assign op_d       = instr_q[31:26];
    assign funct_d    = instr_q[5:0];
    assign pc_plus4_d = pc_plus4_q;
    assign valid_d    = valid_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [15:0] kill_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 32'h0;
            kill_count_q  <= 16'h0;
        end else begin
            if (load && (fetch_count_q != 32'hFFFF_FFFF)) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
            if (kill && (kill_count_q != 16'hFFFF)) begin
                kill_count_q <= kill_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign kill_count  = kill_count_q;
`else
    logic unused_kill;
    assign unused_kill = kill;
`endif

endmodule
